// File: rtl/vis_centroid_if.sv
`default_nettype none
// ============================================================================
// Module   : vis_centroid_if
// Purpose  : Video-in / centroid-out signal bundle for vis_centroid.
// Revision : 1.0
// ============================================================================
interface vis_centroid_if;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        mask;
    logic [10:0] x_center;
    logic [10:0] y_center;
    logic        obj_found;
    logic        ctr_valid;

    modport master (
        output de, hsync, vsync, mask,
        input  x_center, y_center, obj_found, ctr_valid
    );

    modport slave (
        input  de, hsync, vsync, mask,
        output x_center, y_center, obj_found, ctr_valid
    );
endinterface
`default_nettype wire

// File: rtl/vis_centroid.sv
`default_nettype none
// ============================================================================
// Module   : vis_centroid
// Purpose  : Per-frame mask centroid via image moments and restoring division.
// Revision : 1.0
// ============================================================================
module vis_centroid #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int MIN_AREA = 1
) (
    input  logic          clk,
    input  logic          rst,
    vis_centroid_if.slave vif
);

    localparam logic [10:0] c_x_rst    = 11'(IMG_W / 2);
    localparam logic [10:0] c_y_rst    = 11'(IMG_H / 2);
    localparam logic [23:0] c_min_area = 24'(MIN_AREA);
    localparam logic [10:0] c_sat      = 11'h7FF;
    localparam logic [4:0]  c_last_bit = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV_X = 2'd1,
        S_DIV_Y = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        de_prev_q, de_prev_d;
    logic        vsync_prev_q, vsync_prev_d;
    logic        armed_q, armed_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [23:0] m00_q, m00_d;
    logic [31:0] m10_q, m10_d, m01_q, m01_d;
    logic [23:0] cap00_q, cap00_d;
    logic [31:0] cap10_q, cap10_d, cap01_q, cap01_d;
    logic [31:0] quo_q, quo_d;
    logic [23:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [10:0] qx_q, qx_d, qy_q, qy_d;
    logic        found_q, found_d;
    logic [10:0] x_center_q, x_center_d, y_center_q, y_center_d;
    logic        obj_found_q, obj_found_d;
    logic        ctr_valid_q, ctr_valid_d;

    logic        w_pix;
    logic        w_vs_rise;
    logic        w_de_fall;
    logic [23:0] w_m00_sum;
    logic [31:0] w_m10_sum, w_m01_sum;
    logic        w_cap_ok;
    logic [24:0] w_rem_shift;
    logic        w_ge;
    logic [23:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic        w_unused_hsync;

    assign w_unused_hsync = vif.hsync;

    // armed_q masks a spurious edge when vsync is already high coming out of reset
    assign w_pix     = vif.de & vif.mask;
    assign w_vs_rise = vif.vsync & ~vsync_prev_q & armed_q;
    assign w_de_fall = ~vif.de & de_prev_q;

    // Sums include the current pixel so a pixel coinciding with the edge is captured
    assign w_m00_sum = m00_q + {23'd0, w_pix};
    assign w_m10_sum = m10_q + (w_pix ? {21'd0, x_q} : 32'd0);
    assign w_m01_sum = m01_q + (w_pix ? {21'd0, y_q} : 32'd0);
    assign w_cap_ok  = (w_m00_sum != 24'd0) && (w_m00_sum >= c_min_area);

    // Remainder stays below the 24-bit divisor, so 24-bit subtraction is exact
    assign w_rem_shift = {rem_q, quo_q[31]};
    assign w_ge        = (w_rem_shift >= {1'b0, cap00_q});
    assign w_rem_next  = w_ge ? (w_rem_shift[23:0] - cap00_q) : w_rem_shift[23:0];
    assign w_quo_next  = {quo_q[30:0], w_ge};

    always_comb begin
        state_d      = state_q;
        de_prev_d    = vif.de;
        vsync_prev_d = vif.vsync;
        armed_d      = 1'b1;
        x_d          = x_q;
        y_d          = y_q;
        m00_d        = w_m00_sum;
        m10_d        = w_m10_sum;
        m01_d        = w_m01_sum;
        cap00_d      = cap00_q;
        cap10_d      = cap10_q;
        cap01_d      = cap01_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        qx_d         = qx_q;
        qy_d         = qy_q;
        found_d      = found_q;
        x_center_d   = x_center_q;
        y_center_d   = y_center_q;
        obj_found_d  = obj_found_q;
        ctr_valid_d  = 1'b0;

        if (vif.de) begin
            if (x_q != c_sat) x_d = x_q + 11'd1;
        end else if (w_de_fall) begin
            x_d = 11'd0;
        end

        if (w_vs_rise) begin
            y_d = 11'd0;
        end else if (w_de_fall && (y_q != c_sat)) begin
            y_d = y_q + 11'd1;
        end

        if (w_vs_rise) begin
            m00_d = 24'd0;
            m10_d = 32'd0;
            m01_d = 32'd0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_vs_rise) begin
                    cap00_d = w_m00_sum;
                    cap10_d = w_m10_sum;
                    cap01_d = w_m01_sum;
                    found_d = w_cap_ok;
                    if (w_cap_ok) begin
                        quo_d   = w_m10_sum;
                        rem_d   = 24'd0;
                        cnt_d   = 5'd0;
                        state_d = S_DIV_X;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV_X: begin
                quo_d = w_quo_next;
                rem_d = w_rem_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == c_last_bit) begin
                    qx_d    = w_quo_next[10:0];
                    quo_d   = cap01_q;
                    rem_d   = 24'd0;
                    cnt_d   = 5'd0;
                    state_d = S_DIV_Y;
                end
            end
            S_DIV_Y: begin
                quo_d = w_quo_next;
                rem_d = w_rem_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == c_last_bit) begin
                    qy_d    = w_quo_next[10:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ctr_valid_d = 1'b1;
                obj_found_d = found_q;
                if (found_q) begin
                    x_center_d = qx_q;
                    y_center_d = qy_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            de_prev_q    <= 1'b0;
            vsync_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            x_q          <= 11'd0;
            y_q          <= 11'd0;
            m00_q        <= 24'd0;
            m10_q        <= 32'd0;
            m01_q        <= 32'd0;
            cap00_q      <= 24'd0;
            cap10_q      <= 32'd0;
            cap01_q      <= 32'd0;
            quo_q        <= 32'd0;
            rem_q        <= 24'd0;
            cnt_q        <= 5'd0;
            qx_q         <= 11'd0;
            qy_q         <= 11'd0;
            found_q      <= 1'b0;
            x_center_q   <= c_x_rst;
            y_center_q   <= c_y_rst;
            obj_found_q  <= 1'b0;
            ctr_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            de_prev_q    <= de_prev_d;
            vsync_prev_q <= vsync_prev_d;
            armed_q      <= armed_d;
            x_q          <= x_d;
            y_q          <= y_d;
            m00_q        <= m00_d;
            m10_q        <= m10_d;
            m01_q        <= m01_d;
            cap00_q      <= cap00_d;
            cap10_q      <= cap10_d;
            cap01_q      <= cap01_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            qx_q         <= qx_d;
            qy_q         <= qy_d;
            found_q      <= found_d;
            x_center_q   <= x_center_d;
            y_center_q   <= y_center_d;
            obj_found_q  <= obj_found_d;
            ctr_valid_q  <= ctr_valid_d;
        end
    end

    assign vif.x_center  = x_center_q;
    assign vif.y_center  = y_center_q;
    assign vif.obj_found = obj_found_q;
    assign vif.ctr_valid = ctr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vis_centroid.sv
`default_nettype none
// ============================================================================
// Module   : tb_vis_centroid
// Purpose  : Directed frames with hand-computed centroids for vis_centroid.
// Revision : 1.0
// ============================================================================
module tb_vis_centroid;

    logic clk;
    logic rst;
    int   cyc;
    int   vld_cnt;
    int   vld_cyc;
    int   n_checks;
    int   n_errors;

    vis_centroid_if vif();

    vis_centroid #(
        .IMG_W    (64),
        .IMG_H    (64),
        .MIN_AREA (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        vld_cnt = 0;
        vld_cyc = 0;
    end
    always @(negedge clk) begin
        if (vif.ctr_valid === 1'b1) begin
            vld_cnt = vld_cnt + 1;
            vld_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic d, input logic v, input logic m);
        @(negedge clk);
        vif.de    = d;
        vif.vsync = v;
        vif.mask  = m;
        vif.hsync = ~d;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic logic pix(input int mode, input int r, input int c);
        case (mode)
            0:       return (r == 37) && (c == 28);
            1:       return (c >= 10) && (c <= 19) && (r >= 20) && (r <= 29);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Blanking drives mask=1 with de=0; those cycles must not count.
    task automatic send_frame(input int mode);
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) drive(1'b1, 1'b0, pix(mode, r, c));
            repeat (4) drive(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic vsync_pulse(output int e0);
        @(negedge clk);
        vif.de    = 1'b0;
        vif.mask  = 1'b0;
        vif.vsync = 1'b1;
        e0        = cyc + 1;
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_result(input string tag, input int base, input int e0, input int lat,
                                 input int xe, input int ye, input int fe);
        int n;
        n = 0;
        while ((vld_cnt == base) && (n < 200)) begin
            @(negedge clk);
            #2;
            n++;
        end
        check($sformatf("%s_seen", tag), 32'(vld_cnt != base), 32'd1);
        check($sformatf("%s_lat", tag), 32'(vld_cyc - e0), 32'(lat));
        check($sformatf("%s_x", tag), 32'(vif.x_center), 32'(xe));
        check($sformatf("%s_y", tag), 32'(vif.y_center), 32'(ye));
        check($sformatf("%s_found", tag), 32'(vif.obj_found), 32'(fe));
        repeat (3) @(negedge clk);
        #2;
        check($sformatf("%s_strobe", tag), 32'(vld_cnt - base), 32'd1);
        check($sformatf("%s_vld_low", tag), 32'(vif.ctr_valid), 32'd0);
    endtask

    initial begin
        int e0;
        int base;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        vif.de    = 1'b0;
        vif.hsync = 1'b0;
        vif.vsync = 1'b1;
        vif.mask  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(vif.x_center), 32'd32);
        check("rst_y", 32'(vif.y_center), 32'd32);
        check("rst_found", 32'(vif.obj_found), 32'd0);
        check("rst_vld", 32'(vif.ctr_valid), 32'd0);

        // vsync already high when reset releases: no edge may be seen
        rst = 1'b0;
        repeat (5) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (80) @(negedge clk);
        check("no_edge_after_rst", 32'(vld_cnt), 32'd0);

        base = vld_cnt;
        send_frame(0);
        vsync_pulse(e0);
        expect_result("single", base, e0, 65, 28, 37, 1);

        base = vld_cnt;
        send_frame(2);
        vsync_pulse(e0);
        expect_result("empty", base, e0, 1, 28, 37, 0);

        base = vld_cnt;
        send_frame(1);
        vsync_pulse(e0);
        expect_result("rect", base, e0, 65, 14, 24, 1);

        base = vld_cnt;
        send_frame(3);
        vsync_pulse(e0);
        expect_result("full", base, e0, 65, 31, 31, 1);

        // Reset sampled at E0+30 aborts the division
        base = vld_cnt;
        send_frame(0);
        vsync_pulse(e0);
        wait_until(e0 + 29);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        check("abort_no_vld", 32'(vld_cnt - base), 32'd0);
        check("abort_x", 32'(vif.x_center), 32'd32);
        check("abort_y", 32'(vif.y_center), 32'd32);
        check("abort_found", 32'(vif.obj_found), 32'd0);

        base = vld_cnt;
        send_frame(1);
        vsync_pulse(e0);
        expect_result("post_abort", base, e0, 65, 14, 24, 1);

        // Second vsync rise at E0+10 while dividing discards five fresh pixels
        base = vld_cnt;
        send_frame(0);
        vsync_pulse(e0);
        repeat (5) drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        wait_until(e0 + 9);
        check("pre2_m00", 32'(dut.m00_q), 32'd5);
        vif.vsync = 1'b1;
        @(negedge clk);
        check("post2_m00", 32'(dut.m00_q), 32'd0);
        check("post2_m10", dut.m10_q, 32'd0);
        check("post2_m01", dut.m01_q, 32'd0);
        vif.vsync = 1'b0;
        expect_result("double", base, e0, 65, 28, 37, 1);

        base = vld_cnt;
        send_frame(2);
        vsync_pulse(e0);
        expect_result("after_discard", base, e0, 1, 28, 37, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
